// File: rtl/mux_shift_pkg.sv
// Shared types for the selectable, shiftable holding register.
//   op_e    : per-cycle operation encoding on the op port
//   state_e : burst controller states
//   dir_e   : shift direction latched for a burst
package mux_shift_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        SHL  = 2'd2,
        SHR  = 2'd3
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

endpackage : mux_shift_pkg

// File: rtl/mux_shift_ctrl.sv
// Burst controller: FSM, down-counter, latched direction and busy/done.
// Decides per cycle whether the datapath shifts or loads.
//   clk, rst     : clock, async active-low reset
//   clr          : synchronous clear
//   en           : clock enable (also gates burst progress)
//   op           : requested operation (ignored during a burst)
//   start        : burst request, honoured only with SHL/SHR in IDLE
//   nshift       : burst length
//   shift_c      : datapath shifts at this edge (combinational)
//   dir_c        : direction of that shift (combinational)
//   load_c       : datapath loads at this edge (combinational)
//   busy, done   : registered burst status
module mux_shift_ctrl
    import mux_shift_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  op_e              op,
    input  logic             start,
    input  logic [CNT_W-1:0] nshift,
    output logic             shift_c,
    output dir_e             dir_c,
    output logic             load_c,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    dir_e             op_dir;
    logic             busy_d;
    logic             done_d;

    // State and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= LEFT;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, counter and datapath strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy;
        done_d  = 1'b0;
        shift_c = 1'b0;
        load_c  = 1'b0;
        dir_c   = dir_q;
        op_dir  = (op == SHR) ? RIGHT : LEFT;

        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (en) begin
                        unique case (op)
                            HOLD: ;
                            LOAD: load_c = 1'b1;
                            SHL, SHR: begin
                                dir_c = op_dir;
                                if (start) begin
                                    dir_d   = op_dir;
                                    // nshift=0 completes without shifting
                                    shift_c = (nshift != '0);
                                    if (nshift > CNT_W'(1)) begin
                                        cnt_d   = nshift - CNT_W'(1);
                                        state_d = BURST;
                                        busy_d  = 1'b1;
                                    end else begin
                                        done_d = 1'b1;
                                    end
                                end else begin
                                    shift_c = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                BURST: begin
                    if (en) begin
                        shift_c = 1'b1;
                        cnt_d   = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule : mux_shift_ctrl

// File: rtl/mux_shift_reg.sv
// WIDTH-bit holding register with NSRC-way parallel load, left/right
// serial shift and a counted burst-shift mode.
//   clk, rst  : clock, async active-low reset
//   clr       : synchronous clear
//   en        : clock enable
//   op        : 0=HOLD 1=LOAD 2=SHL 3=SHR
//   sel, d    : load source index and packed load sources
//   ser_in    : serial input for shifts
//   start     : burst request; nshift is its length
//   q         : register contents
//   ser_out   : bit most recently shifted out
//   busy,done : burst status
module mux_shift_reg
    import mux_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned SEL_W = $clog2(NSRC),
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic [1:0]                 op,
    input  logic [SEL_W-1:0]           sel,
    input  logic [NSRC-1:0][WIDTH-1:0] d,
    input  logic                       ser_in,
    input  logic                       start,
    input  logic [CNT_W-1:0]           nshift,
    output logic [WIDTH-1:0]           q,
    output logic                       ser_out,
    output logic                       busy,
    output logic                       done
);

    logic             shift_c;
    dir_e             dir_c;
    logic             load_c;
    logic [WIDTH-1:0] load_val;

    mux_shift_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .op      (op_e'(op)),
        .start   (start),
        .nshift  (nshift),
        .shift_c (shift_c),
        .dir_c   (dir_c),
        .load_c  (load_c),
        .busy    (busy),
        .done    (done)
    );

    // Source mux; an out-of-range sel falls back to d[0]
    always_comb begin
        load_val = d[0];
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (sel == i[SEL_W-1:0]) begin
                load_val = d[i[SEL_W-1:0]];
            end
        end
    end

    // Register and serial-out datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= '0;
            ser_out <= 1'b0;
        end else if (clr) begin
            q       <= '0;
            ser_out <= 1'b0;
        end else if (shift_c) begin
            if (dir_c == LEFT) begin
                ser_out <= q[WIDTH-1];
                q       <= {q[WIDTH-2:0], ser_in};
            end else begin
                ser_out <= q[0];
                q       <= {ser_in, q[WIDTH-1:1]};
            end
        end else if (load_c) begin
            q <= load_val;
        end
    end

endmodule : mux_shift_reg

// File: tb/tb_mux_shift_reg.sv
// Self-checking bench for mux_shift_reg (WIDTH=8, NSRC=4).
// A shift-count model is compared every cycle; directed vectors add
// hand-computed expectations.
module tb_mux_shift_reg;

    localparam int W = 8;
    localparam int N = 4;

    logic               clk    = 1'b0;
    logic               rst    = 1'b0;
    logic               clr    = 1'b0;
    logic               en     = 1'b0;
    logic [1:0]         op     = 2'd0;
    logic [1:0]         sel    = 2'd0;
    logic [N-1:0][W-1:0] d     = '0;
    logic               ser_in = 1'b0;
    logic               start  = 1'b0;
    logic [3:0]         nshift = 4'd0;
    logic [W-1:0]       q;
    logic               ser_out;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    mux_shift_reg #(
        .WIDTH (W),
        .NSRC  (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .op      (op),
        .sel     (sel),
        .d       (d),
        .ser_in  (ser_in),
        .start   (start),
        .nshift  (nshift),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Model: register value plus number of burst shifts still owed
    typedef struct {
        int q;
        int so;
        int rem;
        int busy;
        int done;
        int dir;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t shift1(input mstate_t s);
        mstate_t n = s;
        if (n.dir == 0) begin
            n.so = (n.q >> 7) & 1;
            n.q  = ((n.q << 1) | int'(ser_in)) & 255;
        end else begin
            n.so = n.q & 1;
            n.q  = (n.q >> 1) | (int'(ser_in) * 128);
        end
        return n;
    endfunction

    function automatic mstate_t step(input mstate_t s);
        mstate_t n = s;
        n.done = 0;
        if (clr) begin
            n.q = 0; n.so = 0; n.rem = 0; n.busy = 0;
        end else if (s.rem > 0) begin
            if (en) begin
                n = shift1(n);
                n.rem = n.rem - 1;
                if (n.rem == 0) begin
                    n.busy = 0;
                    n.done = 1;
                end
            end
        end else if (en) begin
            if (op == 2'd1) begin
                n.q = int'(d[sel]);
            end else if (op >= 2'd2) begin
                n.dir = (op == 2'd3) ? 1 : 0;
                if (start) begin
                    if (nshift != 4'd0) begin
                        n = shift1(n);
                        n.rem = int'(nshift) - 1;
                    end
                    if (n.rem > 0) n.busy = 1;
                    else           n.done = 1;
                end else begin
                    n = shift1(n);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{default: 0};
        else      m <= step(m);
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cmp_q",       int'(q),       m.q);
        chk("cmp_ser_out", int'(ser_out), m.so);
        chk("cmp_busy",    int'(busy),    m.busy);
        chk("cmp_done",    int'(done),    m.done);
        chk("cmp_busy_done_excl", int'(busy & done), 0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int s, input logic [7:0] v);
        d[s] = v;
        sel  = 2'(s);
        op   = 2'd1;
        tick();
        op   = 2'd0;
    endtask

    // Clocks maxc edges, dropping start after the first; reports burst status
    task automatic watch(input int maxc, output int busy_n, output int done_at,
                         output int q_done, output int so_done);
        busy_n = 0; done_at = -1; q_done = -1; so_done = -1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (i == 0) begin
                start = 1'b0;
                op    = 2'd0;
            end
            if (busy) busy_n++;
            if (done && done_at < 0) begin
                done_at = i;
                q_done  = int'(q);
                so_done = int'(ser_out);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bn, da, qd, sd;

        // Reset values
        tick(); tick();
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ser_out", int'(ser_out), 0);
        rst = 1'b1;
        en  = 1'b1;

        // Parallel load
        d[2] = 8'hA5; d[3] = 8'h3C; sel = 2'd2; op = 2'd1;
        tick(); chk("load_sel2", int'(q), 'hA5);
        sel = 2'd3;
        tick(); chk("load_sel3", int'(q), 'h3C);
        op = 2'd0;

        // Single shifts, hold, enable low
        load(0, 8'h81);
        op = 2'd2; ser_in = 1'b0;
        tick(); chk("shl_q", int'(q), 'h02); chk("shl_so", int'(ser_out), 1);
        op = 2'd3; ser_in = 1'b1;
        tick(); chk("shr_q", int'(q), 'h81); chk("shr_so", int'(ser_out), 0);
        op = 2'd0;
        tick(); chk("hold_q", int'(q), 'h81);
        en = 1'b0; op = 2'd2;
        tick(); chk("en_low_q", int'(q), 'h81);
        en = 1'b1; op = 2'd0;

        // Burst SHR by 4
        load(1, 8'hF0);
        op = 2'd3; start = 1'b1; nshift = 4'd4; ser_in = 1'b0;
        watch(6, bn, da, qd, sd);
        chk("burst_busy_cycles", bn, 3);
        chk("burst_done_at", da, 3);
        chk("burst_q", qd, 'h0F);
        chk("burst_so", sd, 0);

        // Burst SHL by 5 with a 2-cycle stall
        load(0, 8'h01);
        op = 2'd2; start = 1'b1; nshift = 4'd5; ser_in = 1'b1;
        tick(); start = 1'b0; op = 2'd0;
        tick(); en = 1'b0;
        tick(); tick();
        chk("stall_q", int'(q), 'h07);
        chk("stall_busy", int'(busy), 1);
        en = 1'b1;
        watch(5, bn, da, qd, sd);
        chk("stall_done_at", da, 2);
        chk("stall_q_done", qd, 'h3F);

        // clr mid-burst
        load(0, 8'hFF);
        op = 2'd3; start = 1'b1; nshift = 4'd6; ser_in = 1'b0;
        tick(); start = 1'b0; op = 2'd0;
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        chk("clr_q", int'(q), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_done", int'(done), 0);
        watch(4, bn, da, qd, sd);
        chk("clr_no_done", da, -1);
        chk("clr_no_busy", bn, 0);

        // nshift=0 and nshift=1
        load(0, 8'h5A);
        op = 2'd2; start = 1'b1; nshift = 4'd0; ser_in = 1'b1;
        watch(3, bn, da, qd, sd);
        chk("n0_done_at", da, 0); chk("n0_q", qd, 'h5A); chk("n0_busy", bn, 0);
        op = 2'd2; start = 1'b1; nshift = 4'd1; ser_in = 1'b1;
        watch(3, bn, da, qd, sd);
        chk("n1_done_at", da, 0); chk("n1_q", qd, 'hB5);
        chk("n1_so", sd, 0); chk("n1_busy", bn, 0);

        // start with LOAD is a plain load
        d[2] = 8'h77; sel = 2'd2; op = 2'd1; start = 1'b1; nshift = 4'd3;
        watch(3, bn, da, qd, sd);
        chk("ld_start_no_done", da, -1); chk("ld_start_busy", bn, 0);
        chk("ld_start_q", int'(q), 'h77);

        // start during a burst is ignored
        op = 2'd2; start = 1'b1; nshift = 4'd3; ser_in = 1'b0;
        tick(); op = 2'd3; nshift = 4'd2;
        chk("ign_busy1", int'(busy), 1);
        tick(); chk("ign_busy2", int'(busy), 1);
        tick(); chk("ign_done", int'(done), 1); chk("ign_q", int'(q), 'hB8);
        start = 1'b0; op = 2'd0;
        tick(); chk("ign_idle_busy", int'(busy), 0);
        chk("ign_idle_done", int'(done), 0); chk("ign_idle_q", int'(q), 'hB8);

        // Back-to-back bursts
        op = 2'd3; start = 1'b1; nshift = 4'd2; ser_in = 1'b1;
        tick(); chk("b2b_q1", int'(q), 'hDC); chk("b2b_busy1", int'(busy), 1);
        tick(); chk("b2b_q2", int'(q), 'hEE); chk("b2b_done1", int'(done), 1);
        op = 2'd2; nshift = 4'd2; ser_in = 1'b0;
        tick(); chk("b2b_q3", int'(q), 'hDC); chk("b2b_busy2", int'(busy), 1);
        chk("b2b_done_low", int'(done), 0);
        start = 1'b0; op = 2'd0;
        tick(); chk("b2b_q4", int'(q), 'hB8); chk("b2b_done2", int'(done), 1);
        chk("b2b_so", int'(ser_out), 1);

        // nshift > WIDTH
        op = 2'd2; start = 1'b1; nshift = 4'd10; ser_in = 1'b1;
        watch(12, bn, da, qd, sd);
        chk("long_done_at", da, 9); chk("long_q", qd, 'hFF); chk("long_busy", bn, 9);

        // Asynchronous reset mid-burst
        op = 2'd3; start = 1'b1; nshift = 4'd5; ser_in = 1'b0;
        tick(); start = 1'b0; op = 2'd0;
        tick(); chk("arst_pre_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_so", int'(ser_out), 0);
        tick(); rst = 1'b1;
        tick(); chk("arst_after_busy", int'(busy), 0); chk("arst_after_q", int'(q), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_shift_reg
